// File: rtl/fifo_flow_ctrl_pkg.sv
// Shared constants for the per-queue flow-control FIFOs.
// Holds the per-queue pointer widths and the umbrales_I field layout used by
// the control level to split one threshold word into per-instance thresholds.
package fifo_flow_ctrl_pkg;

    localparam int unsigned FIFO_DATA_W = 6;

    // Per-queue pointer widths (depth = 2**ADDR_W)
    localparam int unsigned MF_ADDR_W = 2;
    localparam int unsigned VC_ADDR_W = 4;
    localparam int unsigned D_ADDR_W  = 2;

    // umbrales_I bit-field layout: MF[13:12], VC0[11:8], VC1[7:4], D0[3:2], D1[1:0]
    localparam int unsigned UMBRALES_W  = 14;
    localparam int unsigned UMB_MF_LSB  = 12;
    localparam int unsigned UMB_VC0_LSB = 8;
    localparam int unsigned UMB_VC1_LSB = 4;
    localparam int unsigned UMB_D0_LSB  = 2;
    localparam int unsigned UMB_D1_LSB  = 0;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_flow_ctrl: one synchronous write port and one
// synchronous read port. Storage is not reset; only the read register is.
// Ports: clk, rst (async, active-high, read register only),
//        wr_en/wr_addr/wr_data (write port), rd_en/rd_addr (read request),
//        rd_data (registered read data, holds when rd_en is low).
module fifo_mem #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data holds its value unless a read is requested
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with occupancy-based flow-control status for one queue.
// Ports: clk, reset (async, active-high), init (loads umbral_ae/umbral_af),
//        push/data_in (write), pop (read), data_out/valid_out (registered read),
//        full/empty/almost_full/almost_empty/pause (status compares of the
//        registered count), error (sticky overflow).
module fifo_flow_ctrl
    import fifo_flow_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned ADDR_W = MF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [ADDR_W-1:0] umbral_ae,
    input  logic [ADDR_W-1:0] umbral_af,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              pause,
    output logic              error
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] AE_RST    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AF_RST    = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [ADDR_W-1:0] ae_reg_q, ae_reg_d;
    logic [ADDR_W-1:0] af_reg_q, af_reg_d;
    logic              error_q,  error_d;
    logic              valid_q,  valid_d;
    logic              push_ok;
    logic              pop_ok;

    // Accept logic: a push into a full FIFO only succeeds when a pop frees a slot
    // in the same cycle; an empty FIFO never bypasses push data to the read side.
    always_comb begin
        pop_ok  = pop && (count_q != '0);
        push_ok = push && ((count_q < DEPTH_CNT) || pop_ok);
    end

    // Next-state for pointers, occupancy, thresholds and status
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ae_reg_d = ae_reg_q;
        af_reg_d = af_reg_q;
        error_d  = error_q;
        valid_d  = pop_ok;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        // Dropped push is sticky until reset; init deliberately leaves it alone
        if (push && !push_ok) begin
            error_d = 1'b1;
        end

        if (init) begin
            ae_reg_d = umbral_ae;
            af_reg_d = umbral_af;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ae_reg_q <= AE_RST;
            af_reg_q <= AF_RST;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ae_reg_q <= ae_reg_d;
            af_reg_q <= af_reg_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    // Status flags are pure compares of registered state, so they are glitch-free
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= {1'b0, af_reg_q});
    assign almost_empty = (count_q <= {1'b0, ae_reg_q});
    assign pause        = almost_full;
    assign error        = error_q;
    assign valid_out    = valid_q;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed self-checking bench for fifo_flow_ctrl (DATA_W=6, ADDR_W=2).
module tb_fifo_flow_ctrl;

    logic       clk;
    logic       reset;
    logic       init;
    logic [1:0] umbral_ae;
    logic [1:0] umbral_af;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       pause;
    logic       error;

    int checks;
    int failures;

    fifo_flow_ctrl #(
        .DATA_W (6),
        .ADDR_W (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_ae    (umbral_ae),
        .umbral_af    (umbral_af),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .pause        (pause),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_dat(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // empty, almost_empty, full, almost_full, and pause (which tracks almost_full)
    task automatic chk_flags(input string tag, input logic e, input logic ae,
                             input logic f, input logic af);
        chk_bit({tag, ".empty"},        empty,        e);
        chk_bit({tag, ".almost_empty"}, almost_empty, ae);
        chk_bit({tag, ".full"},         full,         f);
        chk_bit({tag, ".almost_full"},  almost_full,  af);
        chk_bit({tag, ".pause"},        pause,        af);
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the edge
    task automatic cyc(input logic p, input logic [5:0] d, input logic r,
                       input logic in, input logic [1:0] ae, input logic [1:0] af);
        push      = p;
        data_in   = d;
        pop       = r;
        init      = in;
        umbral_ae = ae;
        umbral_af = af;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        init = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        init      = 1'b0;
        umbral_ae = 2'd0;
        umbral_af = 2'd0;
        push      = 1'b0;
        data_in   = 6'h00;
        pop       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset defaults
        chk_flags("rst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_bit("rst.error", error, 1'b0);
        chk_bit("rst.valid", valid_out, 1'b0);
        chk_dat("rst.data", data_out, 6'h00);

        // Fill to full
        cyc(1'b1, 6'h01, 1'b0, 1'b0, 2'd0, 2'd0);
        chk_flags("fill1", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 6'h02, 1'b0, 1'b0, 2'd0, 2'd0);
        chk_flags("fill2", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 6'h03, 1'b0, 1'b0, 2'd0, 2'd0);
        chk_flags("fill3", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 6'h04, 1'b0, 1'b0, 2'd0, 2'd0);
        chk_flags("fill4", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_bit("fill4.valid", valid_out, 1'b0);

        // Push+pop while full: oldest word out, still full, no error
        cyc(1'b1, 6'h05, 1'b1, 1'b0, 2'd0, 2'd0);
        chk_dat("pp_full.data", data_out, 6'h01);
        chk_bit("pp_full.valid", valid_out, 1'b1);
        chk_bit("pp_full.full", full, 1'b1);
        chk_bit("pp_full.error", error, 1'b0);

        // Overflow: word dropped, error sticky
        cyc(1'b1, 6'h06, 1'b0, 1'b0, 2'd0, 2'd0);
        chk_bit("ovf.error", error, 1'b1);
        chk_bit("ovf.full", full, 1'b1);
        chk_bit("ovf.valid", valid_out, 1'b0);

        // Drain: 02..05 in order, 06 was never stored
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 2'd0);
            chk_dat($sformatf("drain%0d.data", i), data_out, 6'(2 + i));
            chk_bit($sformatf("drain%0d.valid", i), valid_out, 1'b1);
            chk_bit($sformatf("drain%0d.error", i), error, 1'b1);
        end
        chk_flags("drained", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 2'd0, 2'd0);
        chk_bit("idle.valid", valid_out, 1'b0);
        chk_dat("idle.data", data_out, 6'h05);

        // Asynchronous reset mid-cycle with a word stored
        cyc(1'b1, 6'h2A, 1'b0, 1'b0, 2'd0, 2'd0);
        chk_bit("pre_arst.empty", empty, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_flags("arst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_bit("arst.error", error, 1'b0);
        chk_bit("arst.valid", valid_out, 1'b0);
        chk_dat("arst.data", data_out, 6'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Push+pop while empty: only the push executes, no bypass
        cyc(1'b1, 6'h07, 1'b1, 1'b0, 2'd0, 2'd0);
        chk_bit("pp_empty.valid", valid_out, 1'b0);
        chk_flags("pp_empty", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 2'd0);
        chk_dat("pp_empty.pop.data", data_out, 6'h07);
        chk_bit("pp_empty.pop.valid", valid_out, 1'b1);
        chk_bit("pp_empty.pop.empty", empty, 1'b1);

        // Pointer wrap: twelve push/pop pairs, occupancy never above 1
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 6'(16 + i), 1'b0, 1'b0, 2'd0, 2'd0);
            chk_bit($sformatf("wrap%0d.push.empty", i), empty, 1'b0);
            chk_bit($sformatf("wrap%0d.push.ae", i), almost_empty, 1'b1);
            cyc(1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 2'd0);
            chk_dat($sformatf("wrap%0d.data", i), data_out, 6'(16 + i));
            chk_bit($sformatf("wrap%0d.valid", i), valid_out, 1'b1);
            chk_bit($sformatf("wrap%0d.empty", i), empty, 1'b1);
        end

        // Pop on empty: ignored, data held
        cyc(1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 2'd0);
        chk_bit("pop_empty.valid", valid_out, 1'b0);
        chk_dat("pop_empty.data", data_out, 6'h1B);
        chk_bit("pop_empty.error", error, 1'b0);
        chk_bit("pop_empty.empty", empty, 1'b1);

        // Threshold reprogram at count 2
        cyc(1'b1, 6'h20, 1'b0, 1'b0, 2'd0, 2'd0);
        cyc(1'b1, 6'h21, 1'b0, 1'b0, 2'd0, 2'd0);
        chk_flags("cnt2", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b1, 2'd2, 2'd2);
        chk_flags("init22", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_bit("init22.error", error, 1'b0);
        chk_bit("init22.valid", valid_out, 1'b0);
        cyc(1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 2'd0);
        chk_dat("init22.pop0", data_out, 6'h20);
        chk_flags("init22.cnt1", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 2'd0);
        chk_dat("init22.pop1", data_out, 6'h21);

        // af_reg = 0 keeps almost_full asserted even when empty
        cyc(1'b0, 6'h00, 1'b0, 1'b1, 2'd0, 2'd0);
        chk_flags("af0", 1'b1, 1'b1, 1'b0, 1'b1);

        // Overflow sets error; init afterwards leaves it set
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 6'(48 + i), 1'b0, 1'b0, 2'd0, 2'd0);
        end
        chk_bit("ovf2.error", error, 1'b1);
        cyc(1'b0, 6'h00, 1'b0, 1'b1, 2'd1, 2'd3);
        chk_bit("init_keep.error", error, 1'b1);
        chk_flags("init_keep", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 2'd0);
        chk_dat("init_keep.data", data_out, 6'h30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
